// File: rtl/game_turn_scheduler.sv
// Turn and round sequencer: alternates RED/BLUE turns under a per-turn
// timer and, after each full round, sweeps the board applying troop growth.
module game_turn_scheduler #(
   parameter int BORAD_WIDTH             = 10,
   parameter int LOG2_BORAD_WIDTH        = 4,
   parameter int LOG2_MAX_PLAYER_CNT     = 3,
   parameter int LOG2_PIECE_TYPE_CNT     = 2,
   parameter int LOG2_MAX_TROOP          = 9,
   parameter int LOG2_MAX_ROUND          = 12,
   parameter int TURN_TIMEOUT_CYCLES     = 1000,
   parameter int TERRITORY_GROWTH_PERIOD = 25
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           turn_done,
   output logic                           busy,
   output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
   output logic [LOG2_MAX_ROUND:0]        round,
   output logic                           turn_timeout,
   output logic                           game_over,
   output logic                           rd_en,
   output logic [LOG2_BORAD_WIDTH-1:0]    rd_h,
   output logic [LOG2_BORAD_WIDTH-1:0]    rd_v,
   input  logic [LOG2_MAX_PLAYER_CNT-1:0] rd_owner,
   input  logic [LOG2_PIECE_TYPE_CNT-1:0] rd_piece_type,
   input  logic [LOG2_MAX_TROOP-1:0]      rd_troop,
   output logic                           wr_en,
   output logic [LOG2_BORAD_WIDTH-1:0]    wr_h,
   output logic [LOG2_BORAD_WIDTH-1:0]    wr_v,
   output logic [LOG2_MAX_TROOP-1:0]      wr_troop
);

   localparam int TW = (TURN_TIMEOUT_CYCLES > 2) ? $clog2(TURN_TIMEOUT_CYCLES) : 1;
   localparam int RW = LOG2_MAX_ROUND + 1;
   localparam int PLW = LOG2_MAX_PLAYER_CNT;
   localparam int PTW = LOG2_PIECE_TYPE_CNT;
   localparam int CW = LOG2_BORAD_WIDTH;

   localparam logic [PLW-1:0] PLAYER_NPC  = PLW'(0);
   localparam logic [PLW-1:0] PLAYER_RED  = PLW'(1);
   localparam logic [PLW-1:0] PLAYER_BLUE = PLW'(2);
   localparam logic [PTW-1:0] PIECE_TERRITORY = PTW'(0);
   localparam logic [PTW-1:0] PIECE_CROWN     = PTW'(2);
   localparam logic [PTW-1:0] PIECE_CITY      = PTW'(3);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TURN_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]  IDX_LAST   = CW'(BORAD_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TURN, S_SWEEP_RD, S_SWEEP_WR, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PLW-1:0]  player_q, player_d;
   logic [RW-1:0]   round_q, round_d;
   logic            timeout_q, timeout_d;
   logic            over_q, over_d;
   logic [CW-1:0]   sh_q, sh_d;
   logic [CW-1:0]   sv_q, sv_d;

   logic            territory_tick;
   logic            grows;
   logic            saturated;
   logic            expired;

   // Growth decision for the cell whose data is on the read port; round_q
   // already holds the round being entered while the sweep runs.
   always_comb begin
      territory_tick = ((round_q % RW'(TERRITORY_GROWTH_PERIOD)) == '0);
      saturated      = &rd_troop;
      grows          = (rd_owner != PLAYER_NPC) &&
                       ((rd_piece_type == PIECE_CROWN) ||
                        (rd_piece_type == PIECE_CITY) ||
                        ((rd_piece_type == PIECE_TERRITORY) && territory_tick));
   end

   // Next-state logic for turn sequencing, timer and sweep index.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      player_d  = player_q;
      round_d   = round_q;
      timeout_d = 1'b0;
      over_d    = over_q;
      sh_d      = sh_q;
      sv_d      = sv_q;
      expired   = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d  = '0;
            player_d = PLAYER_RED;
            if (start) state_d = S_WAIT_TURN;
         end
         S_WAIT_TURN: begin
            timer_d = timer_q + TW'(1);
            expired = (timer_q == TIMER_LAST);
            if (turn_done || expired) begin
               // A settled turn takes precedence; the timeout flag only
               // reports turns that the timer alone ended.
               timeout_d = expired && !turn_done;
               timer_d   = '0;
               if (player_q == PLAYER_RED) begin
                  player_d = PLAYER_BLUE;
               end else if (round_q == '1) begin
                  over_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  round_d  = round_q + RW'(1);
                  player_d = PLAYER_RED;
                  sh_d     = '0;
                  sv_d     = '0;
                  state_d  = S_SWEEP_RD;
               end
            end
         end
         S_SWEEP_RD: state_d = S_SWEEP_WR;
         S_SWEEP_WR: begin
            if ((sh_q == IDX_LAST) && (sv_q == IDX_LAST)) begin
               timer_d = '0;
               state_d = S_WAIT_TURN;
            end else begin
               if (sv_q == IDX_LAST) begin
                  sv_d = '0;
                  sh_d = sh_q + CW'(1);
               end else begin
                  sv_d = sv_q + CW'(1);
               end
               state_d = S_SWEEP_RD;
            end
         end
         default: ; // S_DONE holds everything until reset
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         player_q  <= PLAYER_RED;
         round_q   <= RW'(1);
         timeout_q <= 1'b0;
         over_q    <= 1'b0;
         sh_q      <= '0;
         sv_q      <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         player_q  <= player_d;
         round_q   <= round_d;
         timeout_q <= timeout_d;
         over_q    <= over_d;
         sh_q      <= sh_d;
         sv_q      <= sv_d;
      end
   end

   // Output decode; the write strobe is combinational from the read data.
   always_comb begin
      busy           = (state_q == S_SWEEP_RD) || (state_q == S_SWEEP_WR);
      current_player = player_q;
      round          = round_q;
      turn_timeout   = timeout_q;
      game_over      = over_q;
      rd_en          = (state_q == S_SWEEP_RD);
      rd_h           = sh_q;
      rd_v           = sv_q;
      wr_h           = sh_q;
      wr_v           = sv_q;
      wr_en          = 1'b0;
      wr_troop       = '0;
      if (state_q == S_SWEEP_WR) begin
         wr_en    = grows && !saturated;
         wr_troop = (grows && !saturated) ? rd_troop + LOG2_MAX_TROOP'(1) : rd_troop;
      end
   end

endmodule
